mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response bus between a requester and mem_access_ctrl, plus the
// synchronous data-memory port the controller drives.
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    req;
    logic                    wr;
    logic [1:0]              size;
    logic                    sign_ext;
    logic [ADDR_WIDTH+1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    mem_cs;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_din;
    logic [DATA_WIDTH-1:0]   mem_dout;

    // Controller side
    modport slave (
        input  req, wr, size, sign_ext, addr, wdata, mem_dout,
        output busy, done, err, rdata, mem_cs, mem_we, mem_addr, mem_din
    );

    // Requester / memory-model side
    modport master (
        output req, wr, size, sign_ext, addr, wdata, mem_dout,
        input  busy, done, err, rdata, mem_cs, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/halfword/word load-store controller in front of a synchronous word RAM.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, ERR} state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_wr;
    logic [1:0]              r_size;
    logic                    r_sign_ext;
    logic [1:0]              r_off;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_done;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_mem_cs;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_din;

    logic                    w_accept;
    logic                    w_bad;
    logic [ADDR_WIDTH-1:0]   w_word_addr;
    logic                    w_done_next;
    logic                    w_err_next;
    logic                    w_cs_next;
    logic                    w_we_next;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic [DATA_WIDTH-1:0]   w_din_next;
    logic                    w_rdata_load;
    logic [7:0]              w_sel_byte;
    logic [15:0]             w_sel_half;
    logic [DATA_WIDTH-1:0]   w_load_data;
    logic [DATA_WIDTH-1:0]   w_store_src;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [3:0]              w_lane_hit;

    assign w_accept    = (r_state == IDLE) && bus.req;
    assign w_word_addr = bus.addr[ADDR_WIDTH+1:2];
    assign w_bad       = (bus.size == 2'b11)
                       || ((bus.size == 2'b01) && bus.addr[0])
                       || ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));

    // Load path: pick the addressed lane out of the word the RAM is presenting in CAP
    assign w_sel_byte = bus.mem_dout[{r_off, 3'b000} +: 8];
    assign w_sel_half = bus.mem_dout[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = bus.mem_dout;
        case (r_size)
            2'b00:   w_load_data = r_sign_ext ? {{24{w_sel_byte[7]}}, w_sel_byte}
                                              : {24'b0, w_sel_byte};
            2'b01:   w_load_data = r_sign_ext ? {{16{w_sel_half[15]}}, w_sel_half}
                                              : {16'b0, w_sel_half};
            default: w_load_data = bus.mem_dout;
        endcase
    end

    // Store path: replicate the right-aligned data to every lane, then keep only the hit lanes
    assign w_store_src = (r_size == 2'b00) ? {4{r_wdata[7:0]}} : {2{r_wdata[15:0]}};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_hit[gi] = (r_size == 2'b00) ? (r_off == 2'(gi))
                                                      : (r_off[1] == 1'(gi / 2));
            assign w_merged[8*gi +: 8] = w_lane_hit[gi] ? w_store_src[8*gi +: 8]
                                                        : bus.mem_dout[8*gi +: 8];
        end
    endgenerate

    assign w_rdata_load = (r_state == CAP) && !r_wr;

    // Next state plus the memory-port values for that state, registered below
    always_comb begin
        w_state_next = r_state;
        w_cs_next    = 1'b0;
        w_we_next    = 1'b0;
        w_addr_next  = r_mem_addr;
        w_din_next   = r_mem_din;
        w_done_next  = 1'b0;
        w_err_next   = r_err;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    if (w_bad) begin
                        w_state_next = ERR;
                    end else if (bus.wr && (bus.size == 2'b10)) begin
                        w_state_next = WR;
                        w_cs_next    = 1'b1;
                        w_we_next    = 1'b1;
                        w_addr_next  = w_word_addr;
                        w_din_next   = bus.wdata;
                    end else begin
                        w_state_next = RD;
                        w_cs_next    = 1'b1;
                        w_addr_next  = w_word_addr;
                    end
                end
            end
            RD: begin
                w_state_next = CAP;
            end
            CAP: begin
                if (r_wr) begin
                    w_state_next = WR;
                    w_cs_next    = 1'b1;
                    w_we_next    = 1'b1;
                    w_din_next   = w_merged;
                end else begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                    w_err_next   = 1'b0;
                end
            end
            WR: begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
                w_err_next   = 1'b0;
            end
            ERR: begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
                w_err_next   = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr       <= 1'b0;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_off      <= 2'b00;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_mem_cs   <= w_cs_next;
            r_mem_we   <= w_we_next;
            r_mem_addr <= w_addr_next;
            r_mem_din  <= w_din_next;
            if (w_accept) begin
                r_wr       <= bus.wr;
                r_size     <= bus.size;
                r_sign_ext <= bus.sign_ext;
                r_off      <= bus.addr[1:0];
                r_wdata    <= bus.wdata;
            end
            if (w_rdata_load) begin
                r_rdata <= w_load_data;
            end
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.rdata    = r_rdata;
    assign bus.mem_cs   = r_mem_cs;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of single accesses plus
// hand sequences for reset-abort and back-to-back requests.
module tb_mem_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Synchronous RAM model: write on cs&we, registered read on cs&!we, z when deselected
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] dout_q;
    assign bus_if.mem_dout = dout_q;
    always @(posedge clk) begin
        if (bus_if.mem_cs && bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_din;
        if (bus_if.mem_cs && !bus_if.mem_we) dout_q <= mem[bus_if.mem_addr];
        else if (!bus_if.mem_cs) dout_q <= 'z;
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        se;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          widx;
        logic [31:0] wexp;
    } vec_t;

    vec_t vecs [14];
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // Called #1 after a posedge with state IDLE; next posedge is the accept edge
    task automatic drive(input logic wr, input logic [1:0] size, input logic se,
                         input logic [11:0] addr, input logic [31:0] wdata);
        bus_if.req      = 1'b1;
        bus_if.wr       = wr;
        bus_if.size     = size;
        bus_if.sign_ext = se;
        bus_if.addr     = addr;
        bus_if.wdata    = wdata;
    endtask

    // Wait after the accept edge for done; returns latency (0 = timed out)
    task automatic wait_done(output int lat, output logic cs_seen);
        logic got;
        got = 1'b0;
        lat = 0;
        cs_seen = bus_if.mem_cs;
        for (int k = 1; k <= 8; k++) begin
            if (!got) begin
                @(posedge clk); #1;
                if (bus_if.done) begin
                    got = 1'b1;
                    lat = k + 1;
                end else if (bus_if.mem_cs) begin
                    cs_seen = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int   lat;
        logic cs_seen;
        logic saw_done;

        vecs[0]  = '{1'b0, 2'd2, 1'b0, 12'h000, 32'h0,        3, 1'b0, 32'h000007D1, 0, 32'h000007D1};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 12'h000, 32'h0,        3, 1'b0, 32'hFFFFFFD1, 0, 32'h000007D1};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 12'h000, 32'h0,        3, 1'b0, 32'h000000D1, 0, 32'h000007D1};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 12'h002, 32'h0,        2, 1'b1, 32'h000000D1, 0, 32'h000007D1};
        vecs[4]  = '{1'b0, 2'd3, 1'b0, 12'h000, 32'h0,        2, 1'b1, 32'h000000D1, 0, 32'h000007D1};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 12'h005, 32'h0,        2, 1'b1, 32'h000000D1, 1, 32'h00000FA1};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 12'h002, 32'h0,        3, 1'b0, 32'h00000000, 0, 32'h000007D1};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 12'h005, 32'h000000AB, 4, 1'b0, 32'h00000000, 1, 32'h0000ABA1};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 12'h006, 32'h5A5A1234, 4, 1'b0, 32'h00000000, 1, 32'h1234ABA1};
        vecs[9]  = '{1'b0, 2'd1, 1'b1, 12'h004, 32'h0,        3, 1'b0, 32'hFFFFABA1, 1, 32'h1234ABA1};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 12'h007, 32'h0,        3, 1'b0, 32'h00000012, 1, 32'h1234ABA1};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 12'h00C, 32'hCAFEF00D, 2, 1'b0, 32'h00000012, 3, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 12'h00F, 32'h0,        3, 1'b0, 32'h000000CA, 3, 32'hCAFEF00D};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 12'h001, 32'hDEADBEEF, 2, 1'b1, 32'h000000CA, 0, 32'h000007D1};

        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        mem[0] = 32'h000007D1;
        mem[1] = 32'h00000FA1;
        bus_if.req = 1'b0; bus_if.wr = 1'b0; bus_if.size = 2'b00;
        bus_if.sign_ext = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",     32'(bus_if.busy),     32'h0);
        check("reset_done",     32'(bus_if.done),     32'h0);
        check("reset_err",      32'(bus_if.err),      32'h0);
        check("reset_rdata",    bus_if.rdata,         32'h0);
        check("reset_mem_cs",   32'(bus_if.mem_cs),   32'h0);
        check("reset_mem_we",   32'(bus_if.mem_we),   32'h0);
        check("reset_mem_addr", 32'(bus_if.mem_addr), 32'h0);
        check("reset_mem_din",  bus_if.mem_din,       32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wr, vecs[i].size, vecs[i].se, vecs[i].addr, vecs[i].wdata);
            @(posedge clk); #1;
            bus_if.req = 1'b0;
            check($sformatf("v%0d_busy", i), 32'(bus_if.busy), 32'h1);
            wait_done(lat, cs_seen);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_err", i), 32'(bus_if.err), 32'(vecs[i].err));
            check($sformatf("v%0d_rdata", i), bus_if.rdata, vecs[i].rdata);
            check($sformatf("v%0d_mem", i), mem[vecs[i].widx], vecs[i].wexp);
            if (vecs[i].err) check($sformatf("v%0d_cs_quiet", i), 32'(cs_seen), 32'h0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), 32'(bus_if.done), 32'h0);
            $display("vec %0d: wr=%0d size=%0d addr=0x%03h lat=%0d err=%0d rdata=0x%08h",
                     i, vecs[i].wr, vecs[i].size, vecs[i].addr, lat, bus_if.err, bus_if.rdata);
        end

        // Reset during CAP of a halfword store: the write must never happen
        drive(1'b1, 2'd1, 1'b0, 12'h004, 32'h00005555);
        @(posedge clk); #1;
        bus_if.req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_busy",   32'(bus_if.busy),   32'h0);
        check("abort_mem_cs", 32'(bus_if.mem_cs), 32'h0);
        check("abort_rdata",  bus_if.rdata,       32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus_if.done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'h0);
        check("abort_word1",   mem[1],        32'h1234ABA1);
        $display("abort: busy=%0d word1=0x%08h", bus_if.busy, mem[1]);

        // Word store followed by a load issued in the done cycle
        drive(1'b1, 2'd2, 1'b0, 12'h008, 32'h12345678);
        @(posedge clk); #1;
        bus_if.req = 1'b0;
        wait_done(lat, cs_seen);
        check("b2b_store_latency", 32'(lat), 32'd2);
        drive(1'b0, 2'd2, 1'b0, 12'h008, 32'h0);
        @(posedge clk); #1;
        bus_if.req = 1'b0;
        check("b2b_no_bubble", 32'(bus_if.busy), 32'h1);
        wait_done(lat, cs_seen);
        check("b2b_load_latency", 32'(lat), 32'd3);
        check("b2b_rdata", bus_if.rdata, 32'h12345678);
        check("b2b_err",   32'(bus_if.err), 32'h0);
        $display("b2b: lat=%0d rdata=0x%08h", lat, bus_if.rdata);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
